// File: rtl/uart_rx_oversample_if.sv
// Receiver-side bundle: serial line and oversample tick in, received word and status out.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_oversample_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;

  modport master (input rx, input s_tick, output dout, output rx_done_tick,
                  output frame_err, output parity_err);
  modport slave  (output rx, output s_tick, input dout, input rx_done_tick,
                  input frame_err, input parity_err);
`else
  modport master (input rx, input s_tick, output dout, output rx_done_tick,
                  output frame_err);
  modport slave  (output rx, output s_tick, input dout, input rx_done_tick,
                  input frame_err);
`endif
endinterface

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver: start/data/(parity)/stop FSM driven by s_tick.
// Optional even-parity stage enabled by the UART_RX_PARITY_EN macro.
module uart_rx_oversample #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_rx_oversample_if.master  bus
);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]      state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            rx_sync_p0;
  logic            rx_s;
  logic [DBIT-1:0] dout_r;
  logic            done_r;
  logic            ferr_r;
`ifdef UART_RX_PARITY_EN
  logic            p;
  logic            perr_r;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      s          <= '0;
      n          <= '0;
      b          <= '0;
      dout_r     <= '0;
      done_r     <= 1'b0;
      ferr_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p          <= 1'b0;
      perr_r     <= 1'b0;
`endif
    end else begin
      // stage boundary: two-flop synchroniser on the asynchronous line
      rx_sync_p0 <= bus.rx;
      rx_s       <= rx_sync_p0;
      done_r     <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s == SW'(7)) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s == SW'(15)) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bus.s_tick) begin
            if (s == SW'(15)) begin
              p     <= rx_s;
              s     <= '0;
              state <= STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (bus.s_tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              state  <= IDLE;
              dout_r <= b;
              ferr_r <= ~rx_s;
              done_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_r <= ^{b, p};
`endif
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout         = dout_r;
  assign bus.rx_done_tick = done_r;
  assign bus.frame_err    = ferr_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_r;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample with an expected-frame scoreboard.
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_oversample;
  localparam int BITCLK = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   strobes = 0;
  int   exp_strobes = 0;
  logic prev_done = 1'b0;
  logic [7:0] model_dout = 8'h00;

  uart_rx_oversample_if #(.DBIT(8)) bus ();

  uart_rx_oversample #(.DBIT(8), .SB_TICK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.s_tick = 1'b1;
      @(negedge clk);
      bus.s_tick = 1'b0;
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      exp_t e;
      strobes++;
      chk("strobe_single_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("strobe_expected", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("dout", {24'd0, bus.dout}, {24'd0, e.d});
        chk("frame_err", {31'd0, bus.frame_err}, {31'd0, e.fe});
`ifdef UART_RX_PARITY_EN
        chk("parity_err", {31'd0, bus.parity_err}, {31'd0, e.pe});
`endif
      end
    end
    prev_done = bus.rx_done_tick;
  end

  task automatic bit_out(input logic v, input int len);
    bus.rx = v;
    repeat (len) @(negedge clk);
  endtask

  // stop_len lets a bad stop bit end early so its trailing low half is not read as a new start
  task automatic frame(input logic [7:0] d, input logic stopv, input logic parv, input int stop_len);
    exp_t e;
    e.d  = d;
    e.fe = ~stopv;
    e.pe = ^{d, parv};
    sb.push_back(e);
    exp_strobes++;
    model_dout = d;
    bit_out(1'b0, BITCLK);
    for (int i = 0; i < 8; i++) bit_out(d[i], BITCLK);
`ifdef UART_RX_PARITY_EN
    bit_out(parv, BITCLK);
`endif
    bit_out(stopv, stop_len);
    bus.rx = 1'b1;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_dout", {24'd0, bus.dout}, 32'd0);
    chk("reset_done", {31'd0, bus.rx_done_tick}, 32'd0);
    chk("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("reset_parity_err", {31'd0, bus.parity_err}, 32'd0);
`endif
    reset = 1'b1;
    bit_out(1'b1, 2 * BITCLK);

    frame(8'h55, 1'b1, 1'b0, BITCLK);
    drain();
    bit_out(1'b1, BITCLK);
    chk("count_after_55", strobes, exp_strobes);

    // start glitch: 4 ticks low, then idle long enough for the abort to finish
    bit_out(1'b0, 16);
    bit_out(1'b1, 3 * BITCLK);
    chk("glitch_no_strobe", strobes, exp_strobes);
    chk("glitch_dout", {24'd0, bus.dout}, {24'd0, model_dout});

    frame(8'hA3, 1'b0, 1'b0, 48);
    drain();
    bit_out(1'b1, 2 * BITCLK);
    chk("count_after_stop_err", strobes, exp_strobes);
    frame(8'h3C, 1'b1, 1'b0, BITCLK);
    drain();

    frame(8'h00, 1'b1, 1'b0, BITCLK);
    frame(8'hFF, 1'b1, 1'b0, BITCLK);
    drain();
    bit_out(1'b1, BITCLK);
    chk("count_back_to_back", strobes, exp_strobes);
    chk("dout_after_ff", {24'd0, bus.dout}, 32'h0000_00FF);

    // 0x81 cut short by reset in the middle of data bit 3
    bit_out(1'b0, BITCLK);
    bit_out(1'b1, BITCLK);
    bit_out(1'b0, BITCLK);
    bit_out(1'b0, BITCLK);
    bit_out(1'b0, BITCLK / 2);
    reset  = 1'b0;
    bus.rx = 1'b1;
    model_dout = 8'h00;
    repeat (8) @(negedge clk);
    chk("midreset_dout", {24'd0, bus.dout}, {24'd0, model_dout});
    chk("midreset_done", {31'd0, bus.rx_done_tick}, 32'd0);
    chk("midreset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    reset = 1'b1;
    bit_out(1'b1, 2 * BITCLK);
    chk("midreset_no_strobe", strobes, exp_strobes);
    frame(8'h42, 1'b1, 1'b0, BITCLK);
    drain();
    bit_out(1'b1, BITCLK);

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b0, BITCLK);
    drain();
    frame(8'h07, 1'b1, 1'b1, BITCLK);
    drain();
    bit_out(1'b1, BITCLK);
`endif

    chk("final_strobe_count", strobes, exp_strobes);
    chk("final_dout", {24'd0, bus.dout}, {24'd0, model_dout});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
